// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
//  regfile_wb_pkg
//  Shared constants and slot-state encoding for the writeback arbiter.
//  Revision: 1.0
// ============================================================================
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE           = 3'd0;
  localparam state_t ST_ALU_ONLY       = 3'd1;
  localparam state_t ST_MEM_ONLY       = 3'd2;
  localparam state_t ST_BOTH_ALU_OLDER = 3'd3;
  localparam state_t ST_BOTH_MEM_OLDER = 3'd4;

endpackage : regfile_wb_pkg
`default_nettype wire

// File: rtl/dec_5to32.sv
`default_nettype none
// ============================================================================
//  dec_5to32
//  Plain 5-to-32 one-hot decoder.
//  Revision: 1.0
// ============================================================================
module dec_5to32
  import regfile_wb_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_sel,
  output logic [NUM_REGS-1:0]   o_onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign o_onehot[i] = (i_sel == 5'(i));
  end

endmodule : dec_5to32
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  regfile_wb_arbiter
//  Oldest-first arbitration of ALU and load writebacks onto one regfile port.
//  Revision: 1.0
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [NUM_REGS-1:0]   wr_onehot,
  output logic [NUM_REGS-1:0]   busy_mask
);

  state_t                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   alu_rd_q, alu_rd_d, mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0]       alu_data_q, alu_data_d, mem_data_q, mem_data_d;

  logic w_alu_full, w_mem_full, w_grant_alu, w_grant_mem;
  logic w_alu_keep, w_mem_keep, w_alu_load, w_mem_load;
  logic [NUM_REGS-1:0] w_wr_dec, w_alu_dec, w_mem_dec;

  // Slot occupancy and grant are pure decodes of the registered state.
  assign w_alu_full  = (state_q == ST_ALU_ONLY) || (state_q == ST_BOTH_ALU_OLDER) ||
                       (state_q == ST_BOTH_MEM_OLDER);
  assign w_mem_full  = (state_q == ST_MEM_ONLY) || (state_q == ST_BOTH_ALU_OLDER) ||
                       (state_q == ST_BOTH_MEM_OLDER);
  assign w_grant_alu = (state_q == ST_ALU_ONLY) || (state_q == ST_BOTH_ALU_OLDER);
  assign w_grant_mem = (state_q == ST_MEM_ONLY) || (state_q == ST_BOTH_MEM_OLDER);

  assign alu_ready = ~reset & (~w_alu_full | w_grant_alu);
  assign mem_ready = ~reset & (~w_mem_full | w_grant_mem);

  // Writes to r0 complete the handshake but never occupy a slot.
  assign w_alu_keep = w_alu_full & ~w_grant_alu;
  assign w_mem_keep = w_mem_full & ~w_grant_mem;
  assign w_alu_load = alu_valid & alu_ready & (alu_rd != REG_ZERO);
  assign w_mem_load = mem_valid & mem_ready & (mem_rd != REG_ZERO);

  always_comb begin
    state_d    = ST_IDLE;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (w_alu_load) begin
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end
    if (w_mem_load) begin
      mem_rd_d   = mem_rd;
      mem_data_d = mem_data;
    end
    // A slot that was held through the edge is older than a fresh load;
    // two fresh loads on the same edge put mem first.
    if ((w_alu_keep || w_alu_load) && (w_mem_keep || w_mem_load)) begin
      state_d = w_alu_keep ? ST_BOTH_ALU_OLDER : ST_BOTH_MEM_OLDER;
    end else if (w_alu_keep || w_alu_load) begin
      state_d = ST_ALU_ONLY;
    end else if (w_mem_keep || w_mem_load) begin
      state_d = ST_MEM_ONLY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!reset && w_grant_alu) begin
      wr_en   = 1'b1;
      wr_addr = alu_rd_q;
      wr_data = alu_data_q;
    end else if (!reset && w_grant_mem) begin
      wr_en   = 1'b1;
      wr_addr = mem_rd_q;
      wr_data = mem_data_q;
    end
  end

  dec_5to32 u_dec_wr  (.i_sel(wr_addr),  .o_onehot(w_wr_dec));
  dec_5to32 u_dec_alu (.i_sel(alu_rd_q), .o_onehot(w_alu_dec));
  dec_5to32 u_dec_mem (.i_sel(mem_rd_q), .o_onehot(w_mem_dec));

  assign wr_onehot = w_wr_dec & {NUM_REGS{wr_en}};
  assign busy_mask = ((w_alu_dec & {NUM_REGS{w_alu_full}}) |
                      (w_mem_dec & {NUM_REGS{w_mem_full}})) & {NUM_REGS{~reset}};

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_regfile_wb_arbiter
//  Directed self-checking bench for the writeback arbiter.
//  Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, wr_onehot, busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_onehot(wr_onehot), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                        input logic [31:0] d);
    logic [31:0] oh;
    oh = en ? (32'h1 << a) : 32'h0;
    chk({tag, "_en"},     {31'd0, wr_en},   {31'd0, en});
    chk({tag, "_addr"},   {27'd0, wr_addr}, en ? {27'd0, a} : 32'd0);
    chk({tag, "_data"},   wr_data,          en ? d : 32'd0);
    chk({tag, "_onehot"}, wr_onehot,        oh);
  endtask

  task automatic chk_rdy(input string tag, input logic ar, input logic mr);
    chk({tag, "_alu_rdy"}, {31'd0, alu_ready}, {31'd0, ar});
    chk({tag, "_mem_rdy"}, {31'd0, mem_ready}, {31'd0, mr});
  endtask

  initial begin
    logic [31:0] exp_d;
    logic [4:0]  exp_a;

    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;

    // Reset state
    step(); step();
    chk_rdy("rst", 1'b0, 1'b0);
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_busy", busy_mask, 32'h0);
    reset = 1'b0;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b1);

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    chk_wr("single", 1'b1, 5'd5, 32'h1234);
    chk("single_busy", busy_mask, 32'h20);
    step();
    chk_wr("single_after", 1'b0, 5'd0, 32'd0);
    chk("single_busy_after", busy_mask, 32'h0);

    // Simultaneous requests to the same register: mem first, alu last
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hB;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk_wr("simul1", 1'b1, 5'd3, 32'hB);
    chk("simul1_busy", busy_mask, 32'h8);
    chk_rdy("simul1", 1'b0, 1'b1);
    step();
    chk_wr("simul2", 1'b1, 5'd3, 32'hA);
    step();
    chk_wr("simul3", 1'b0, 5'd0, 32'd0);
    chk_rdy("simul3", 1'b1, 1'b1);

    // Back-pressure: both valid for 20 cycles, then drain
    for (int j = 0; j < 23; j++) begin
      if (j == 0) begin
        chk_rdy("bp0", 1'b1, 1'b1);
        chk_wr("bp0", 1'b0, 5'd0, 32'd0);
      end else if (j <= 21) begin
        if (j % 2 == 1) begin
          exp_a = 5'd9;
          exp_d = 32'h200 + ((j == 1) ? 32'd0 : 32'(j - 2));
        end else begin
          exp_a = 5'd7;
          exp_d = 32'h100 + 32'(j - 2);
        end
        chk_wr($sformatf("bp%0d", j), 1'b1, exp_a, exp_d);
        if (j <= 20)
          chk_rdy($sformatf("bp%0d", j), (j % 2 == 0), (j % 2 == 1));
      end else begin
        chk_wr("bp_drained", 1'b0, 5'd0, 32'd0);
      end
      alu_valid = (j < 20); alu_rd = 5'd7; alu_data = 32'h100 + 32'(j);
      mem_valid = (j < 20); mem_rd = 5'd9; mem_data = 32'h200 + 32'(j);
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Zero register: handshake completes, nothing written or marked busy
    chk_rdy("zero_pre", 1'b1, 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
    step();
    mem_valid = 1'b0;
    chk_wr("zero", 1'b0, 5'd0, 32'd0);
    chk("zero_busy", busy_mask, 32'h0);
    chk_rdy("zero", 1'b1, 1'b1);
    step();
    chk_wr("zero2", 1'b0, 5'd0, 32'd0);

    // Reset mid-stream with both slots full
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("midrst_busy_pre", busy_mask, 32'h50);
    reset = 1'b1;
    #1;
    chk_wr("midrst", 1'b0, 5'd0, 32'd0);
    chk_rdy("midrst", 1'b0, 1'b0);
    chk("midrst_busy", busy_mask, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk_wr("midrst_after", 1'b0, 5'd0, 32'd0);
    chk_rdy("midrst_after", 1'b1, 1'b1);
    chk("midrst_busy_after", busy_mask, 32'h0);
    step();
    chk_wr("midrst_after2", 1'b0, 5'd0, 32'd0);

    // Aging: a held slot wins over a freshly refilled one
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB0;
    step();
    chk_wr("age1", 1'b1, 5'd11, 32'hB0);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hB1;
    step();
    chk_wr("age2", 1'b1, 5'd10, 32'hA0);
    chk_rdy("age2", 1'b1, 1'b0);
    chk("age2_busy", busy_mask, 32'h1400);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hA1;
    step();
    alu_valid = 1'b0;
    chk_wr("age3", 1'b1, 5'd12, 32'hB1);
    chk_rdy("age3", 1'b0, 1'b1);
    step();
    chk_wr("age4", 1'b1, 5'd13, 32'hA1);
    step();
    chk_wr("age5", 1'b0, 5'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
